// File: rtl/core_pkg.sv
// Shared core definitions: instruction width, default PC width and reset
// vector, and the fetch-unit state encoding.
package core_pkg;

  localparam int          INST_WIDTH      = 32;
  localparam int          CORE_DATA_WIDTH = 32;
  localparam logic [31:0] CORE_RESET_PC   = 32'h8000_0000;

  // FETCH_REQ  : a request may be driven to instruction memory
  // FETCH_WAIT : exactly one request is outstanding
  typedef enum logic [0:0] {
    FETCH_REQ  = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush.
// Ports: clk/rst_n (async active-low), push/push_data write side,
// pop/pop_data read side (pop_data is the head entry, valid when !empty),
// flush empties the FIFO and wins over push/pop in the same cycle,
// count/empty/full occupancy status.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit.
// Issues sequential fetch requests to instruction memory (one outstanding at
// most), buffers returned words with their PCs in a small FIFO and presents
// the head to decode. A redirect reloads the fetch PC, flushes the buffer and
// kills any response still in flight.
// Ports: i_clk, i_rst_n (async active-low); i_redirect_en/i_redirect_pc
// redirect strobe and target; o_imem_req_valid/i_imem_req_ready/
// o_imem_req_addr fetch request; i_imem_rsp_valid/i_imem_rsp_data fetch
// response (always accepted); o_inst_valid/i_inst_ready/o_inst/
// o_inst_opcode/o_inst_pc decode side; dbg_state/dbg_fifo_count expose the
// fetch state and buffer occupancy for observation.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer, except that a redirect may withdraw/replace a pending request.
module ifu
  import core_pkg::*;
#(
  parameter int                    DATA_WIDTH = CORE_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(CORE_RESET_PC),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_redirect_en,
  input  logic [DATA_WIDTH-1:0]         i_redirect_pc,
  output logic                          o_imem_req_valid,
  input  logic                          i_imem_req_ready,
  output logic [DATA_WIDTH-1:0]         o_imem_req_addr,
  input  logic                          i_imem_rsp_valid,
  input  logic [INST_WIDTH-1:0]         i_imem_rsp_data,
  output logic                          o_inst_valid,
  input  logic                          i_inst_ready,
  output logic [INST_WIDTH-1:0]         o_inst,
  output logic [6:0]                    o_inst_opcode,
  output logic [DATA_WIDTH-1:0]         o_inst_pc,
  output fetch_state_t                  dbg_state,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] dbg_fifo_count
);

  localparam int EW = DATA_WIDTH + INST_WIDTH;

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] req_pc;
  logic                  kill;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  req_fire;
  logic                  rsp_take;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         head;
  logic                  fifo_empty;
  logic                  fifo_full;

  assign redirect_target = i_redirect_pc & ~DATA_WIDTH'(3);

  // In REQ nothing is outstanding, so "count + outstanding < depth" reduces
  // to "not full". Gating with i_rst_n keeps valid low during reset while
  // still allowing the first request in the first cycle after release.
  assign o_imem_req_valid = i_rst_n && (state == FETCH_REQ) && !fifo_full;
  assign o_imem_req_addr  = fetch_pc;

  assign req_fire = o_imem_req_valid && i_imem_req_ready;
  assign rsp_take = (state == FETCH_WAIT) && i_imem_rsp_valid;
  // A response is dropped if it was killed earlier or lands on a redirect.
  assign push     = rsp_take && !kill && !i_redirect_en;
  assign pop      = o_inst_valid && i_inst_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= FETCH_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      kill     <= 1'b0;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (req_fire) begin
            state  <= FETCH_WAIT;
            req_pc <= fetch_pc;
            // A request accepted on a redirect edge belongs to the old path.
            kill   <= i_redirect_en;
          end
        end
        FETCH_WAIT: begin
          if (rsp_take) begin
            state <= FETCH_REQ;
            kill  <= 1'b0;
          end else if (i_redirect_en) begin
            kill  <= 1'b1;
          end
        end
        default: state <= FETCH_REQ;
      endcase

      if (i_redirect_en)  fetch_pc <= redirect_target;
      else if (req_fire)  fetch_pc <= fetch_pc + DATA_WIDTH'(4);
    end
  end

  fifo_sync #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data ({req_pc, i_imem_rsp_data}),
    .pop       (pop),
    .flush     (i_redirect_en),
    .pop_data  (head),
    .count     (dbg_fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Outputs read as zero while empty so nothing stale is ever visible.
  assign o_inst_valid  = !fifo_empty;
  assign o_inst        = fifo_empty ? '0 : head[INST_WIDTH-1:0];
  assign o_inst_pc     = fifo_empty ? '0 : head[EW-1:INST_WIDTH];
  assign o_inst_opcode = o_inst[6:0];
  assign dbg_state     = state;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the fetch stream.
module tb_ifu;
  import core_pkg::*;

  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_redirect_en;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [6:0]  o_inst_opcode;
  logic [31:0] o_inst_pc;
  fetch_state_t dbg_state;
  logic [1:0]  dbg_fifo_count;

  always #5 i_clk = ~i_clk;

  ifu #(
    .DATA_WIDTH (DW),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_redirect_en    (i_redirect_en),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_inst           (o_inst),
    .o_inst_opcode    (o_inst_opcode),
    .o_inst_pc        (o_inst_pc),
    .dbg_state        (dbg_state),
    .dbg_fifo_count   (dbg_fifo_count)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds {pc, inst} of every instruction decode should still see.
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  bit          pending;
  logic [31:0] pend_addr;
  int          pend_epoch;
  int          epoch   = 0;
  int          lat     = 0;
  int          lat_max = 0;
  bit          force_nop = 1'b0;
  logic [31:0] acc_q[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (force_nop) return 32'h0000_0013;
    return (a * 32'h0019_660D) + 32'h3C6E_F35F;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_pc  = RPC;
    pending = 1'b0;
    epoch++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(o_imem_req_valid), 64'(0));
    check({tag, "_req_addr"},  64'(o_imem_req_addr),  64'(RPC));
    check({tag, "_inst_valid"},64'(o_inst_valid),     64'(0));
    check({tag, "_inst"},      64'(o_inst),           64'(0));
    check({tag, "_opcode"},    64'(o_inst_opcode),    64'(0));
    check({tag, "_inst_pc"},   64'(o_inst_pc),        64'(0));
    check({tag, "_state"},     64'(dbg_state),        64'(FETCH_REQ));
    check({tag, "_count"},     64'(dbg_fifo_count),   64'(0));
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered at a falling edge: check outputs, drive inputs, advance model.
  task automatic step(input bit rdy, input bit inst_rdy, input bit redir, input logic [31:0] rpc);
    bit          exp_req_valid;
    bit          exp_inst_valid;
    bit          req_fire;
    bit          rsp;
    logic [31:0] rsp_data;
    #1;
    exp_req_valid  = !pending && (exp_q.size() < DEPTH);
    exp_inst_valid = (exp_q.size() > 0);
    check("req_valid", 64'(o_imem_req_valid), 64'(exp_req_valid));
    if (exp_req_valid) check("req_addr", 64'(o_imem_req_addr), 64'(exp_pc));
    check("inst_valid", 64'(o_inst_valid), 64'(exp_inst_valid));
    if (exp_inst_valid) begin
      check("inst",    64'(o_inst),        64'(exp_q[0][31:0]));
      check("inst_pc", 64'(o_inst_pc),     64'(exp_q[0][63:32]));
      check("opcode",  64'(o_inst_opcode), 64'(exp_q[0][6:0]));
    end

    rsp      = pending && (lat == 0);
    rsp_data = rsp ? mem_data(pend_addr) : $urandom();
    i_imem_req_ready = rdy;
    i_inst_ready     = inst_rdy;
    i_redirect_en    = redir;
    i_redirect_pc    = rpc;
    i_imem_rsp_valid = rsp;
    i_imem_rsp_data  = rsp_data;
    if (pending && lat > 0) lat--;

    req_fire = exp_req_valid && rdy;
    if (req_fire) acc_q.push_back(o_imem_req_addr);
    if (exp_inst_valid && inst_rdy) begin
      pop_log.push_back(o_inst_pc);
      void'(exp_q.pop_front());
    end
    if (rsp) begin
      if (pend_epoch == epoch && !redir) exp_q.push_back({pend_addr, rsp_data});
      pending = 1'b0;
    end
    if (req_fire) begin
      pending    = 1'b1;
      pend_addr  = exp_pc;
      pend_epoch = epoch;
      exp_pc     = exp_pc + 32'd4;
      lat        = $urandom_range(0, lat_max);
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      exp_pc = rpc & 32'hFFFF_FFFC;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic run_until_pending(input string tag);
    for (int k = 0; k < 30 && !pending; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check(tag, 64'(pending), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n          = 1'b1;
    i_redirect_en    = 1'b0;
    i_redirect_pc    = '0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_inst_ready     = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("por_held");
    i_rst_n = 1'b1;
    model_reset();

    // Sequential fetch with single-cycle memory latency.
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("seq_req0", 64'(qget(acc_q, 0)), 64'(32'h8000_0000));
    check("seq_req1", 64'(qget(acc_q, 1)), 64'(32'h8000_0004));
    check("seq_req2", 64'(qget(acc_q, 2)), 64'(32'h8000_0008));
    check("seq_pc0",  64'(qget(pop_log, 0)), 64'(32'h8000_0000));
    check("seq_pc1",  64'(qget(pop_log, 1)), 64'(32'h8000_0004));
    check("seq_pc2",  64'(qget(pop_log, 2)), 64'(32'h8000_0008));

    // Decode stalled: buffer fills to its depth and requests stop.
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_req_valid", 64'(o_imem_req_valid), 64'(0));
    check("stall_count",     64'(dbg_fifo_count),   64'(DEPTH));

    // Redirect while waiting: in-flight response must be dropped.
    lat_max = 3;
    run_until_pending("wait_for_redirect");
    lat = 2;
    acc_q.delete();
    step(1'b1, 1'b1, 1'b1, 32'h8000_0103);
    check("redir_flush_valid", 64'(o_inst_valid), 64'(0));
    check("redir_kill_state",  64'(dbg_state),    64'(FETCH_WAIT));
    for (int k = 0; k < 12 && acc_q.size() == 0; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_next_addr", 64'(qget(acc_q, 0)), 64'(32'h8000_0100));

    // Redirect coincident with a response and a pop.
    lat_max = 0;
    for (int k = 0; k < 30 && !(pending && exp_q.size() > 0); k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("coinc_setup", 64'(pending && exp_q.size() > 0), 64'(1));
    lat = 0;
    step(1'b1, 1'b1, 1'b1, 32'h8000_0200);
    check("coinc_inst_valid", 64'(o_inst_valid),   64'(0));
    check("coinc_count",      64'(dbg_fifo_count), 64'(0));
    check("coinc_state",      64'(dbg_state),      64'(FETCH_REQ));

    // Address wrap at the top of the address space.
    acc_q.delete();
    pop_log.delete();
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int k = 0; k < 12 && pop_log.size() < 2; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_req0", 64'(qget(acc_q, 0)),   64'(32'hFFFF_FFFC));
    check("wrap_req1", 64'(qget(acc_q, 1)),   64'(32'h0000_0000));
    check("wrap_pc0",  64'(qget(pop_log, 0)), 64'(32'hFFFF_FFFC));
    check("wrap_pc1",  64'(qget(pop_log, 1)), 64'(32'h0000_0000));

    // Opcode extraction for an ADDI/NOP word.
    force_nop = 1'b1;
    step(1'b0, 1'b1, 1'b1, 32'h0000_1000);
    for (int k = 0; k < 12 && !o_inst_valid; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("nop_opcode", 64'(o_inst_opcode), 64'(7'b0010011));
    check("nop_pc",     64'(o_inst_pc),     64'(32'h0000_1000));
    force_nop = 1'b0;

    // Randomized traffic.
    lat_max = 3;
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 4, rpc);
    end

    // Asynchronous reset in the middle of an outstanding fetch.
    lat_max = 3;
    run_until_pending("wait_for_reset");
    #3 i_rst_n = 1'b0;
    #1 check_reset_outputs("mid_wait_rst");
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_inst_ready     = 1'b0;
    i_redirect_en    = 1'b0;
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, meaning PC/address width.
REQ-002 The block SHALL expose parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL expose parameter FIFO_DEPTH, default 2, meaning decode-side instruction buffer entries.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_redirect_en  input  1  branch/jump redirect strobe.
REQ-007 i_redirect_pc  input  DATA_WIDTH  redirect target.
REQ-008 o_imem_req_valid  output  1  fetch request valid.
REQ-009 i_imem_req_ready  input  1  instruction memory accepts request.
REQ-010 o_imem_req_addr  output  DATA_WIDTH  fetch address.
REQ-011 i_imem_rsp_valid  input  1  fetch response valid (always accepted).
REQ-012 i_imem_rsp_data  input  32  fetched instruction word.
REQ-013 o_inst_valid  output  1  instruction available to decode.
REQ-014 i_inst_ready  input  1  decode consumes instruction.
REQ-015 o_inst  output  32  instruction word to decode/immediate generator.
REQ-016 o_inst_opcode  output  7  o_inst[6:0].
REQ-017 o_inst_pc  output  DATA_WIDTH  PC of o_inst.

Function
REQ-018 States SHALL be REQ (request driven) and WAIT (one request outstanding); at most one outstanding request.
REQ-019 REQ SHALL drive o_imem_req_valid=1 only when fifo_count + outstanding < FIFO_DEPTH; otherwise valid=0 and state holds.
REQ-020 REQ->WAIT on valid&&ready, latching the request PC and advancing fetch PC by 4 (modulo 2^DATA_WIDTH, wrap from 0xFFFF_FFFC to 0).
REQ-021 WAIT->REQ on i_imem_rsp_valid; the response SHALL be written into the FIFO with its latched PC unless the kill flag is set.
REQ-022 o_imem_req_addr and o_imem_req_valid SHALL be stable while valid=1 and ready=0, unless a redirect occurs.
REQ-023 Decode handshake: entry pops on o_inst_valid&&i_inst_ready; o_inst_valid = FIFO non-empty; o_inst/o_inst_pc/o_inst_opcode come from FIFO head, registered; FIFO write-to-o_inst_valid latency 1 cycle.
REQ-024 Simultaneous FIFO push and pop SHALL keep count unchanged; push into full FIFO SHALL be impossible by REQ-019.
REQ-025 i_redirect_en SHALL, in the same edge: load fetch PC with {i_redirect_pc[DATA_WIDTH-1:2],2'b00}, flush FIFO (o_inst_valid=0 next cycle), deassert any pending un-accepted request.
REQ-026 Redirect while in WAIT SHALL set kill flag; the next response is discarded, kill cleared, state->REQ.
REQ-027 Redirect coincident with i_imem_rsp_valid SHALL discard that response and not set kill.
REQ-028 Redirect coincident with request acceptance SHALL treat the accepted request as killed (state WAIT, kill=1).
REQ-029 Redirect coincident with a decode pop SHALL give flush priority; popped instruction is still considered consumed.
REQ-030 First request after reset SHALL be issued in the first cycle with i_rst_n high, address RESET_PC.

Reset
REQ-031 i_rst_n low SHALL asynchronously force: state REQ, fetch PC=RESET_PC, kill=0, FIFO empty, o_imem_req_valid=0, o_inst_valid=0, o_inst=0, o_inst_opcode=0, o_inst_pc=0, o_imem_req_addr=RESET_PC.
REQ-032 Reset asserted mid-WAIT SHALL drop the outstanding transaction; the memory subsystem is reset concurrently.

Structure
REQ-033 INST_WIDTH, DATA_WIDTH, RESET_PC defaults and the fetch-state enum SHALL live in shared package core_pkg.
REQ-034 The buffer SHALL be a sub-module fifo_sync (parameterised width/depth, push/pop/flush, count, empty/full), reusable elsewhere.

Verification
REQ-035 Reset release, ready=1, 1-cycle response latency -> requests 0x8000_0000, 0x8000_0004, 0x8000_0008; o_inst_pc follows in order.
REQ-036 i_inst_ready=0 for 10 cycles -> exactly 2 instructions buffered, o_imem_req_valid=0 thereafter, no response lost.
REQ-037 Redirect to 0x8000_0103 while WAIT -> response discarded, next request addr 0x8000_0100, o_inst_valid=0 cycle after redirect.
REQ-038 Redirect coincident with rsp_valid and with pop -> FIFO empty next cycle, no stale instruction ever presented.
REQ-039 Redirect to 0xFFFF_FFFC -> next two request addresses 0xFFFF_FFFC, 0x0000_0000.
REQ-040 Response data 0x0000_0013 -> o_inst_opcode=7'b0010011; i_rst_n dropped mid-WAIT -> all outputs at REQ-031 values asynchronously.
